// File: rtl/v810_pkg.sv
// v810_pkg: shared types, system-register indices and PSW/SR helpers for the exception sequencer
//   psw_t       - V810 PSW layout (i[19:16], np[15], ep[14], ae[13], id[12], flags[9:0])
//   exc_mode_t  - entry flavour chosen in DECIDE
//   seq_state_t - sequencer states
//   psw_entry   - PSW value written on entry for a given mode
//   sr_write    - system-register write (index + data) for one step of an entry sequence
package v810_pkg;

    typedef struct packed {
        logic [11:0] rsv_hi;
        logic [3:0]  i;
        logic        np;
        logic        ep;
        logic        ae;
        logic        id;
        logic [1:0]  rsv_lo;
        logic [9:0]  flags;
    } psw_t;

    localparam logic [4:0]  SR_EIPC   = 5'd0;
    localparam logic [4:0]  SR_EIPSW  = 5'd1;
    localparam logic [4:0]  SR_FEPC   = 5'd2;
    localparam logic [4:0]  SR_FEPSW  = 5'd3;
    localparam logic [4:0]  SR_ECR    = 5'd4;
    localparam logic [4:0]  SR_PSW    = 5'd5;
    localparam logic [15:0] CC_RESET  = 16'hFFF0;
    localparam logic [31:0] PSW_RESET = 32'h0000_8000;

    typedef enum logic [1:0] {EI, FE, RST, FATAL} exc_mode_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACK,
        S_DECIDE,
        S_WRITE,
        S_VEC,
        S_DUMP,
        S_HALT
    } seq_state_t;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } sr_wr_t;

    function automatic psw_t psw_entry(psw_t psw, exc_mode_t mode, logic [3:0] iel);
        psw_t p;
        p = psw;
        if (mode == RST) begin
            p = PSW_RESET;
        end else if (mode != FATAL) begin
            p.id = 1'b1;
            p.ae = 1'b0;
            if (mode == FE) begin
                p.np = 1'b1;
            end else begin
                p.ep = 1'b1;
                if (iel != 4'd0) p.i = iel;
            end
        end
        return p;
    endfunction

    // Step k of the common order is PC save, PSW save, ECR, new PSW.
    // A reset entry only performs the last two, so its steps start at slot 2.
    function automatic sr_wr_t sr_write(exc_mode_t mode, logic [1:0] idx, psw_t psw,
                                        logic [31:0] pc, logic [31:0] ecr,
                                        logic [15:0] cc, logic [3:0] iel);
        sr_wr_t w;
        logic [1:0] k;
        logic fe;
        fe = (mode == FE);
        k = (mode == RST) ? idx + 2'd2 : idx;
        case (k)
            2'd0: begin
                w.addr = fe ? SR_FEPC : SR_EIPC;
                w.data = pc;
            end
            2'd1: begin
                w.addr = fe ? SR_FEPSW : SR_EIPSW;
                w.data = psw;
            end
            2'd2: begin
                w.addr = SR_ECR;
                w.data = (mode == RST) ? {16'h0000, CC_RESET} :
                         fe ? {cc, ecr[15:0]} : {ecr[31:16], cc};
            end
            default: begin
                w.addr = SR_PSW;
                w.data = psw_entry(psw, mode, iel);
            end
        endcase
        return w;
    endfunction

endpackage

// File: rtl/v810_exc_seq.sv
// v810_exc_seq: interrupt/exception entry sequencer (SR saves, new PSW, fetch redirect, fatal dump)
//   CLK, RESn (async, active-low), CE (global enable)
//   PSW, PC, ECR, BOUND        - EU state at the instruction boundary
//   IF / ACK, NP, IEL, CC, HA  - handshake and latched request from v810_inex
//   BUSY                       - EU stall while the sequencer is active
//   SR_WE, SR_ADDR, SR_WD      - one system-register write per cycle
//   REDIR, REDIR_PC, REDIR_ACK - fetch redirect to the handler
//   MEM_REQ, MEM_A, MEM_D, MEM_ACK - fatal-dump writes to FATAL_BASE+0/4/8
//   HALT                       - stopped after a fatal exception until reset
module v810_exc_seq
    import v810_pkg::*;
#(
    parameter logic [31:0] FATAL_BASE = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RESn,
    input  logic        CE,
    input  psw_t        PSW,
    input  logic [31:0] PC,
    input  logic [31:0] ECR,
    input  logic        BOUND,
    input  logic        IF,
    input  logic        NP,
    input  logic [3:0]  IEL,
    input  logic [15:0] CC,
    input  logic [31:0] HA,
    output logic        ACK,
    output logic        BUSY,
    output logic        SR_WE,
    output logic [4:0]  SR_ADDR,
    output logic [31:0] SR_WD,
    output logic        REDIR,
    output logic [31:0] REDIR_PC,
    input  logic        REDIR_ACK,
    output logic        MEM_REQ,
    output logic [31:0] MEM_A,
    output logic [31:0] MEM_D,
    input  logic        MEM_ACK,
    output logic        HALT
);

    seq_state_t  state, state_d;
    logic [1:0]  idx, idx_d, last_idx;
    exc_mode_t   mode_q, mode_sel, mode_s;
    logic [31:0] psw_q, psw_s, pc_q, pc_s, ecr_q, ecr_s, ha_q, ha_s;
    logic [15:0] cc_q, cc_s;
    logic [3:0]  iel_q, iel_s;
    logic        decide;
    sr_wr_t      wr;
    logic        ack_d, busy_d, sr_we_d, redir_d, mem_req_d, halt_d;
    logic [4:0]  sr_addr_d;
    logic [31:0] sr_wd_d, redir_pc_d, mem_a_d, mem_d_d;

    // The first write/dump word is launched from DECIDE, in the same cycle the
    // request is captured, so that cycle reads the live inputs instead of the holding registers.
    assign decide   = (state == S_DECIDE);
    assign mode_sel = (CC == CC_RESET) ? RST : PSW.np ? FATAL : NP ? FE : EI;
    assign mode_s   = decide ? mode_sel : mode_q;
    assign psw_s    = decide ? PSW : psw_q;
    assign pc_s     = decide ? PC : pc_q;
    assign ecr_s    = decide ? ECR : ecr_q;
    assign ha_s     = decide ? HA : ha_q;
    assign cc_s     = decide ? CC : cc_q;
    assign iel_s    = decide ? IEL : iel_q;
    assign last_idx = (mode_s == RST) ? 2'd1 : 2'd3;

    always_comb begin
        state_d = state;
        idx_d   = idx;
        case (state)
            S_IDLE:   state_d = (IF && BOUND) ? S_ACK : S_IDLE;
            S_ACK:    state_d = S_DECIDE;
            S_DECIDE: begin
                state_d = (mode_s == FATAL) ? S_DUMP : S_WRITE;
                idx_d   = 2'd0;
            end
            S_WRITE: begin
                state_d = (idx == last_idx) ? S_VEC : S_WRITE;
                idx_d   = idx + 2'd1;
            end
            S_VEC:    state_d = REDIR_ACK ? S_IDLE : S_VEC;
            S_DUMP: begin
                if (MEM_ACK) begin
                    state_d = (idx == 2'd2) ? S_HALT : S_DUMP;
                    idx_d   = idx + 2'd1;
                end
            end
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_IDLE;
        endcase
        wr         = sr_write(mode_s, idx_d, psw_s, pc_s, ecr_s, cc_s, iel_s);
        ack_d      = (state_d == S_ACK);
        busy_d     = (state_d != S_IDLE);
        sr_we_d    = (state_d == S_WRITE);
        sr_addr_d  = sr_we_d ? wr.addr : 5'd0;
        sr_wd_d    = sr_we_d ? wr.data : 32'd0;
        redir_d    = (state_d == S_VEC);
        redir_pc_d = redir_d ? ha_s : 32'd0;
        mem_req_d  = (state_d == S_DUMP);
        mem_a_d    = mem_req_d ? FATAL_BASE + {28'd0, idx_d, 2'b00} : 32'd0;
        mem_d_d    = !mem_req_d ? 32'd0 :
                     (idx_d == 2'd0) ? {16'hFFFF, cc_s} :
                     (idx_d == 2'd1) ? psw_s : pc_s;
        halt_d     = (state_d == S_HALT);
    end

    always_ff @(posedge CLK or negedge RESn) begin
        if (!RESn) begin
            state    <= S_IDLE;
            idx      <= 2'd0;
            mode_q   <= EI;
            psw_q    <= '0;
            pc_q     <= '0;
            ecr_q    <= '0;
            ha_q     <= '0;
            cc_q     <= '0;
            iel_q    <= '0;
            ACK      <= 1'b0;
            BUSY     <= 1'b0;
            SR_WE    <= 1'b0;
            SR_ADDR  <= '0;
            SR_WD    <= '0;
            REDIR    <= 1'b0;
            REDIR_PC <= '0;
            MEM_REQ  <= 1'b0;
            MEM_A    <= '0;
            MEM_D    <= '0;
            HALT     <= 1'b0;
        end else if (CE) begin
            state <= state_d;
            idx   <= idx_d;
            if (decide) begin
                mode_q <= mode_sel;
                psw_q  <= PSW;
                pc_q   <= PC;
                ecr_q  <= ECR;
                ha_q   <= HA;
                cc_q   <= CC;
                iel_q  <= IEL;
            end
            ACK      <= ack_d;
            BUSY     <= busy_d;
            SR_WE    <= sr_we_d;
            SR_ADDR  <= sr_addr_d;
            SR_WD    <= sr_wd_d;
            REDIR    <= redir_d;
            REDIR_PC <= redir_pc_d;
            MEM_REQ  <= mem_req_d;
            MEM_A    <= mem_a_d;
            MEM_D    <= mem_d_d;
            HALT     <= halt_d;
        end
    end

endmodule

// File: doc/v810_exc_seq.md
Name: v810_exc_seq

Overview:
- Sequencer for interrupt/exception entry.
- Handshakes with v810_inex, the interrupt/exception multiplexer, and takes its latched CC/HA/NP/IEL.
- Saves PC, PSW and code into the system registers, writes the new PSW, and redirects fetch to the handler.
- On a fatal exception (exception while PSW.NP=1), performs the three-word memory dump, then halts until reset.

Parameters:
- FATAL_BASE, 32'h0000_0000, byte address of the fatal-dump record (words at +0, +4, +8).

Ports:
- CLK  in  1  clock
- RESn  in  1  reset, asynchronous, active-low
- CE  in  1  global clock enable; every state change and output update is gated by it
- PSW  in  psw_t  current PSW
- PC  in  32  restore PC supplied by the EU
- ECR  in  32  current ECR {FECC, EICC}
- BOUND  in  1  EU is at an instruction boundary and can accept an exception
- IF  in  1  interrupt/exception pending, from v810_inex
- NP  in  1  NMI or duplexed exception; valid the cycle after ACK
- IEL  in  4  new PSW.I value (0 means "not an interrupt"); valid the cycle after ACK
- CC  in  16  exception code; valid the cycle after ACK
- HA  in  32  handler address; valid the cycle after ACK
- ACK  out  1  one-cycle acknowledge to v810_inex
- BUSY  out  1  stalls the EU while the sequencer is active
- SR_WE  out  1  system-register write strobe
- SR_ADDR  out  5  system-register index
- SR_WD  out  32  system-register write data
- REDIR  out  1  fetch-redirect request
- REDIR_PC  out  32  redirect target
- REDIR_ACK  in  1  fetch unit accepted the redirect
- MEM_REQ  out  1  fatal-dump write request
- MEM_A  out  32  fatal-dump write address
- MEM_D  out  32  fatal-dump write data
- MEM_ACK  in  1  memory write completed
- HALT  out  1  processor stopped after a fatal exception

Behaviour:
- Outputs are registered.
- Reset (RESn=0, asynchronous): state IDLE; all outputs 0.
- A reset in the middle of any sequence aborts it immediately. There is no partial-write recovery.

State flow:
- IDLE: when IF & BOUND, go to ACKS. Otherwise stay.
- ACKS: ACK=1 for exactly one CE cycle; go to DECIDE.
- DECIDE: capture CC, HA, NP, IEL, PSW, PC and ECR into holding registers. Select the mode by this priority:
  - RST if CC==16'hFFF0
  - else FATAL if PSW.np
  - else FE if NP
  - else EI
- The writes below are issued one per CE cycle, in the order listed, each with SR_WE=1 for one cycle.
- EI:
  - EIPC <= PC
  - EIPSW <= PSW
  - ECR <= {ECR[31:16], CC}
  - PSW <= PSW with ep=1, id=1, ae=0, and i=IEL if IEL!=0
- FE:
  - FEPC <= PC
  - FEPSW <= PSW
  - ECR <= {CC, ECR[15:0]}
  - PSW <= PSW with np=1, id=1, ae=0
- RST:
  - ECR <= 32'h0000_FFF0
  - PSW <= 32'h0000_8000
  - No PC/PSW save.
- After the last write: state VEC. REDIR=1 and REDIR_PC=HA held until REDIR_ACK, then IDLE.
- The RST target is HA, which is FFFFFFF0 from v810_inex.
- FATAL (MEM_REQ/MEM_A/MEM_D held until MEM_ACK, then the next write):
  - FATAL_BASE+0 <= {16'hFFFF, CC}
  - FATAL_BASE+4 <= PSW
  - FATAL_BASE+8 <= PC
  - Then HALT: HALT=1, BUSY=1. Only RESn exits.

Rules and boundary conditions:
- BUSY=1 in every state except IDLE.
- SR writes are never stalled (the register file accepts one write per cycle).
- Minimum latency, EI/FE: IF&BOUND at cycle 0 → ACK cycle 1 → DECIDE 2 → writes 3–6 → REDIR from cycle 7.
- Minimum latency, RST: REDIR from cycle 5.
- IF deasserting after ACK does not cancel the sequence; the held CC/HA values are used.
- IF still high on return to IDLE (a new or stacked request) is serviced normally; no cycle is skipped.
- CE=0 freezes the state and all outputs, including the ACK pulse width.
- REDIR_ACK or MEM_ACK arriving in the same cycle the request first rises is accepted.

Decomposition:
- In v810_pkg:
  - SR index constants: EIPC=0, EIPSW=1, FEPC=2, FEPSW=3, ECR=4, PSW=5.
  - exc_mode_t enum {EI, FE, RST, FATAL}.
  - Sequencer state enum.
  - Function psw_entry(psw_t, mode, iel) returning the new PSW.
- No sub-module; a single FSM with an index counter.

Test Plan:
- PSW=0, PC=32'h0700_0010, IF with CC=FE40/HA=FFFFFE40/IEL=5 → writes EIPC=07000010, EIPSW=0, ECR.EICC=FE40, PSW.ep=1/id=1/i=5; REDIR_PC=FFFFFE40; ACK high exactly 1 cycle.
- PSW.ep=1, CC=FF60, NP=1, HA=FFFFFFD0 → FEPC/FEPSW written; ECR={FF60, old EICC}; PSW.np=1; REDIR_PC=FFFFFFD0.
- Reset exception, CC=FFF0 → only ECR=0000FFF0 and PSW=00008000 written; REDIR_PC=FFFFFFF0 at cycle 5.
- PSW.np=1, CC=FF90 → MEM writes 0:FFFFFF90, 4:PSW, 8:PC with MEM_ACK delayed 3 cycles each; HALT=1 thereafter; IF ignored.
- RESn asserted during the EI write of EIPSW → all outputs 0 immediately; after release, a reset exception sequence runs cleanly.
- CE toggled 1-of-3 cycles during an EI sequence → identical write order and data; ACK spans exactly one CE-enabled cycle.
